// File: rtl/imem_loader.sv
// Byte-stream program loader: length header then little-endian 16-bit words into instruction memory.
// Optional trailing checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_data,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DAT_LO, DAT_HI, DONE, ERR, CK_LO, CK_HI} state_t;
    localparam state_t S_END = CK_LO;
`else
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DAT_LO, DAT_HI, DONE, ERR} state_t;
    localparam state_t S_END = DONE;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_lo;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [15:0] w_pair;
    logic        w_accept;
    logic        w_write;
    logic        w_last;
    logic        w_too_long;
    logic        w_restart;
    logic        w_ready_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] r_sum;
`endif

    // Low byte of every pair is latched on accept; the high byte completes it combinationally.
    assign w_pair     = {byte_data, r_lo};
    assign w_accept   = byte_valid & byte_ready;
    assign w_write    = w_accept && (r_state == DAT_HI);
    assign w_last     = (r_idx + 16'd1) == r_len;
    assign w_too_long = {16'd0, w_pair} > $unsigned(MEM_WORDS);
    assign w_restart  = reload && ((r_state == DONE) || (r_state == ERR));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEN_LO: if (w_accept) w_state_next = LEN_HI;
            LEN_HI: begin
                if (w_accept) begin
                    if (w_pair == 16'd0)  w_state_next = S_END;
                    else if (w_too_long)  w_state_next = ERR;
                    else                  w_state_next = DAT_LO;
                end
            end
            DAT_LO: if (w_accept) w_state_next = DAT_HI;
            DAT_HI: if (w_accept) w_state_next = w_last ? S_END : DAT_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CK_LO:  if (w_accept) w_state_next = CK_HI;
            CK_HI:  if (w_accept) w_state_next = (w_pair == r_sum) ? DONE : ERR;
`endif
            DONE, ERR: if (reload) w_state_next = LEN_LO;
            default: w_state_next = LEN_LO;
        endcase
        w_ready_next = (w_state_next != DONE) && (w_state_next != ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LEN_LO;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 16'd0;
            imem_data  <= 16'd0;
            r_lo       <= 8'd0;
            r_len      <= 16'd0;
            r_idx      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= 16'd0;
`endif
        end else begin
            r_state    <= w_state_next;
            byte_ready <= w_ready_next;
            imem_we    <= w_write;
            if (w_accept) r_lo <= byte_data;
            if (w_accept && (r_state == LEN_HI)) r_len <= w_pair;
            if (w_write) begin
                imem_addr <= r_idx;
                imem_data <= w_pair;
                r_idx     <= r_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum     <= r_sum + w_pair;
`endif
            end
            if (w_restart) begin
                r_idx <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum <= 16'd0;
`endif
            end
        end
    end

    assign core_rst = (r_state != DONE);
    assign done     = (r_state == DONE);
    assign error    = (r_state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads against a
// stream-level reference model (expected writes, final status, checksum as a modular sum).
module tb_imem_loader;
    localparam int MEM_WORDS = 4096;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CKE = 1'b1;
`else
    localparam bit CKE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        reload = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        core_rst;
    logic        done;
    logic        error;

    int          checks = 0;
    int          failures = 0;
    int          bad_we = 0;
    int          cyc = 0;
    bit          rl_noise = 1'b0;
    logic [31:0] wr_q[$];
    logic [15:0] words[MEM_WORDS];

    imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_data(imem_data), .core_rst(core_rst),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_data});
        if (!rst && imem_we) bad_we++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte after `gap` idle cycles; returns at the negedge following acceptance.
    task automatic send(input logic [7:0] b, input int gap);
        logic ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (rl_noise) reload = 1'($urandom_range(0, 1));
            @(negedge clk);
            reload = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 64 && !ok; t++) begin
            ok = byte_ready;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    endtask

    function automatic int gap_of(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    // Stream a complete load of words[0..n-1] and compare against the expected outcome.
    task automatic run_load(input string tag, input int n, input int mode, input int ck_adj);
        int   sum;
        int   nb;
        int   nexp;
        int   ck;
        logic exp_done;
        wr_q.delete();
        cyc = 0;
        sum = 0;
        nb  = 2;
        send(n[7:0], gap_of(mode));
        send(n[15:8], gap_of(mode));
        if (n <= MEM_WORDS) begin
            for (int i = 0; i < n; i++) begin
                send(words[i][7:0], gap_of(mode));
                send(words[i][15:8], gap_of(mode));
                sum = (sum + int'(words[i])) % 65536;
                nb += 2;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck = (sum + ck_adj) % 65536;
            send(ck[7:0], gap_of(mode));
            send(ck[15:8], gap_of(mode));
            nb += 2;
`else
            ck = ck_adj;
`endif
        end
        exp_done = (n <= MEM_WORDS) && (!CKE || ck_adj == 0);
        chk({tag, ".done"},       32'(done),       32'(exp_done));
        chk({tag, ".error"},      32'(error),      32'(!exp_done));
        chk({tag, ".core_rst"},   32'(core_rst),   32'(!exp_done));
        chk({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
        if (mode == 0) chk({tag, ".cycles"}, 32'(cyc), 32'(nb));
        @(negedge clk);
        nexp = (n <= MEM_WORDS) ? n : 0;
        chk({tag, ".wr_count"}, 32'(wr_q.size()), 32'(nexp));
        for (int i = 0; i < nexp; i++)
            chk({tag, ".wr"}, wr_q[i], {i[15:0], words[i]});
        if (nexp > 0)
            chk({tag, ".hold"}, {imem_addr, imem_data}, {16'(nexp - 1), words[nexp - 1]});
    endtask

    // Reload with a byte offered in the same cycle; that byte must not be consumed.
    task automatic do_reload(input string tag);
        reload     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        @(negedge clk);
        reload     = 1'b0;
        byte_valid = 1'b0;
        chk({tag, ".rl_ready"},    32'(byte_ready), 32'd1);
        chk({tag, ".rl_done"},     32'(done),       32'd0);
        chk({tag, ".rl_error"},    32'(error),      32'd0);
        chk({tag, ".rl_core_rst"}, 32'(core_rst),   32'd1);
    endtask

    initial begin
        #3 rst = 1'b0;
        #5;
        chk("rst.byte_ready", 32'(byte_ready), 32'd0);
        chk("rst.imem_we",    32'(imem_we),    32'd0);
        chk("rst.addr_data",  {imem_addr, imem_data}, 32'd0);
        chk("rst.core_rst",   32'(core_rst),   32'd1);
        chk("rst.done",       32'(done),       32'd0);
        chk("rst.error",      32'(error),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("rel.byte_ready_low", 32'(byte_ready), 32'd0);
        @(negedge clk);
        chk("rel.byte_ready_high", 32'(byte_ready), 32'd1);

        words[0] = 16'h0013; words[1] = 16'h1237; words[2] = 16'hFFFF;
        run_load("seq3", 3, 0, 0);
        do_reload("seq3");

        words[0] = 16'hDEAD;
        run_load("toggle", 1, 1, 0);
        do_reload("toggle");

        run_load("len1001", 16'h1001, 0, 0);
        do_reload("len1001");
        for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
        run_load("after_err", 5, 2, 0);
        do_reload("after_err");

        run_load("zero", 0, 0, 0);
        do_reload("zero");

        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        send(8'd4, 0); send(8'd0, 0);
        for (int i = 0; i < 2; i++) begin
            send(words[i][7:0], 0);
            send(words[i][15:8], 0);
        end
        #2 rst = 1'b0;
        #1;
        chk("midrst.byte_ready", 32'(byte_ready), 32'd0);
        chk("midrst.imem_we",    32'(imem_we),    32'd0);
        chk("midrst.addr_data",  {imem_addr, imem_data}, 32'd0);
        chk("midrst.status",     {29'd0, core_rst, done, error}, 32'b100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) words[i] = 16'($urandom);
        run_load("after_rst", 2, 0, 0);
        do_reload("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 16'h8000; words[1] = 16'h8001;
        run_load("ck_good", 2, 0, 0);
        do_reload("ck_good");
        run_load("ck_bad", 2, 0, 1);
        do_reload("ck_bad");
`endif

        rl_noise = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            run_load("rand", n, 2, (k == 3) ? 5 : 0);
            do_reload("rand");
        end
        rl_noise = 1'b0;

        run_load("rand_long", int'($urandom_range(MEM_WORDS + 1, 65535)), 2, 0);
        do_reload("rand_long");

        for (int i = 0; i < MEM_WORDS; i++) words[i] = 16'($urandom);
        run_load("full", MEM_WORDS, 0, 0);

        chk("no_we_in_reset", 32'(bad_we), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
